mac_accumulator: RTL
====================

# mac_accumulator

Sequential accumulate stage sitting directly downstream of the processor's combinational 8-bit multiplier. It consumes a stream of products over a valid/ready handshake, sums a programmed number of them into a wide saturating accumulator, and presents the total to the consumer over a second valid/ready handshake. It turns the single-cycle multiplier into a multiply-accumulate path for dot-product style instructions.

## Interface

- W, 8, product width; matches the multiplier's output width
- ACC_W, 16, accumulator/result width; must be ≥ W
- CNT_W, 4, width of the beat-count field LEN

- CLK  input  1  clock; all state updates on the rising edge
- RESET_N  input  1  asynchronous, active-low reset
- START  input  1  begin a new accumulation; sampled only in IDLE
- LEN  input  CNT_W  number of products to accumulate; sampled with START
- PROD  input  W  product from the multiplier, unsigned
- PROD_VALID  input  1  PROD is valid this cycle
- PROD_READY  output  1  block accepts PROD this cycle
- ACC_OUT  output  ACC_W  accumulated result
- OUT_VALID  output  1  ACC_OUT holds a final result
- OUT_READY  input  1  consumer accepts the result
- BUSY  output  1  high in ACCUM and DONE
- OVF  output  1  sticky flag: saturation occurred in the current/last accumulation

## Operation

- One clock (CLK); reset is asynchronous and active-low (RESET_N).
- States: IDLE, ACCUM, DONE.
- IDLE: PROD_READY=0, OUT_VALID=0, BUSY=0. START=1 is accepted, which clears acc and OVF and latches LEN into the beat counter. If LEN≠0, go to ACCUM. If LEN=0, go to DONE with acc=0.
- ACCUM: PROD_READY=1, BUSY=1. A beat is accepted when PROD_VALID && PROD_READY.
  - acc ← sat(acc + zero-extend(PROD)); counter decrements.
  - The beat that brings the counter from 1 to 0 moves the block to DONE.
  - Cycles without PROD_VALID leave all state unchanged.
  - START is ignored in ACCUM.
- DONE: OUT_VALID=1, BUSY=1, PROD_READY=0, and ACC_OUT is stable. OUT_READY=1 returns the block to IDLE. START is ignored in DONE, including in the same cycle as the output handshake.
- Arithmetic is unsigned. The sum is computed at ACC_W+1 bits.
  - If the sum is ≥ 2^ACC_W, acc ← all ones and OVF ← 1.
  - OVF stays set until the next accepted START clears it.
  - Once saturated, acc stays all ones for the rest of the accumulation.
- ACC_OUT is driven directly from the acc register at all times. It is meaningful only while OUT_VALID=1, and it keeps its value through IDLE until the next START.

## Timing

- Reset values (asynchronous, immediate on RESET_N=0):
  - state=IDLE, acc=0, counter=0
  - ACC_OUT=0, OUT_VALID=0, PROD_READY=0, BUSY=0, OVF=0
- Reset asserted mid-ACCUM or mid-DONE abandons the operation. The pending result is lost and OUT_VALID drops immediately.
- START accepted at edge t: PROD_READY=1 from cycle t+1 (for LEN≠0). For LEN=0, OUT_VALID=1 from cycle t+1.
- Last beat accepted at edge t: PROD_READY=0 and OUT_VALID=1 from cycle t+1, with the final acc visible.
- Minimum latency with PROD_VALID held high is LEN+1 cycles from START to OUT_VALID.
- Output handshake at edge t: OUT_VALID=0 from t+1. A new START can be accepted at edge t+1 at the earliest.
- OUT_VALID and ACC_OUT must not change while OUT_VALID=1 && OUT_READY=0.
- All outputs are registered or decoded from state only. There is no combinational path from PROD_VALID or OUT_READY to any output.

## Test plan

- Basic: START with LEN=3, then PROD 3, 6, 9 with PROD_VALID held high.
  - Required: OUT_VALID rises 4 cycles after START with ACC_OUT=18 and OVF=0.
  - Then pulse OUT_READY. Required: BUSY=0 the next cycle.
- Bubbles and backpressure: LEN=2, PROD 10 and 20 separated by 3 idle cycles. Hold OUT_READY=0 for 5 cycles.
  - Required: ACC_OUT stays at 30 with OUT_VALID=1 throughout.
  - Required: a START pulse during the hold is ignored.
- Saturation (ACC_W=16): LEN=15 with PROD=255 on every beat gives a total of 3825, so no overflow and OVF=0.
  - Rerun with ACC_W=10 and LEN=5: required ACC_OUT=1023 and OVF=1.
  - A following START with LEN=1, PROD=1: required ACC_OUT=1 and OVF=0.
- Zero length: START with LEN=0.
  - Required: OUT_VALID=1 the next cycle with ACC_OUT=0.
  - Required: PROD_READY never asserts.
- Reset mid-operation: LEN=4. After 2 beats, drive RESET_N low between clock edges.
  - Required: all outputs go to their reset values immediately.
  - After release, START with LEN=1, PROD=7: required ACC_OUT=7.
- Back-to-back: output handshake at edge t, START with LEN=1 at edge t+1, PROD=5 with PROD_VALID high.
  - Required: OUT_VALID again at t+3 with ACC_OUT=5.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums LEN unsigned products into a saturating ACC_W-bit accumulator.
// Latency: LEN+1 cycles from START to OUT_VALID when PROD_VALID is held high.
// Backpressure: PROD_READY only in ACCUM; the result is held in DONE until OUT_READY.
module mac_accumulator #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  input  logic [W-1:0]     PROD,
  input  logic             PROD_VALID,
  output logic             PROD_READY,
  output logic [ACC_W-1:0] ACC_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic             OVF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;

  // One extra bit of headroom: a carry into bit ACC_W means the true sum overflowed
  always_comb begin
    sum = {1'b0, acc} + {{(ACC_W + 1 - W){1'b0}}, PROD};
  end

  // Handshake outputs are pure state decodes, so no input reaches an output combinationally
  assign PROD_READY = (state == ACCUM);
  assign OUT_VALID  = (state == DONE);
  assign BUSY       = (state != IDLE);
  assign ACC_OUT    = acc;
  assign OVF        = ovf;

  // Control FSM plus accumulator datapath; START is only honoured in IDLE
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= LEN;
            state <= (LEN != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (PROD_VALID) begin
            // Saturated acc plus any product either carries out or stays all ones
            if (sum[ACC_W]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= sum[ACC_W-1:0];
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
